// File: rtl/chaining_record_pkg.sv
// Shared constants, record layout and group-relative register arithmetic
// for the chaining write-hazard record.
package chaining_record_pkg;

    localparam int unsigned ELEM_PER_REG = 512;
    localparam int unsigned GROUP_REGS   = 8;
    localparam int unsigned OFFSET_W     = 9;
    localparam int unsigned INST_W       = 3;
    localparam int unsigned REG_W        = 5;
    localparam int unsigned REL_W        = 3;
    localparam int unsigned MASK_W       = ELEM_PER_REG * GROUP_REGS;

    typedef struct packed {
        logic              vd_valid;
        logic [REG_W-1:0]  vd_bits;
        logic              vs1_valid;
        logic [REG_W-1:0]  vs1_bits;
        logic [REG_W-1:0]  vs2;
        logic [INST_W-1:0] inst_index;
        logic              gather;
        logic              gather16;
        logic              only_read;
    } record_t;

    // Register distance from the group base, wrapping modulo the register file size.
    function automatic logic [REG_W-1:0] rel_group(input logic [REG_W-1:0] vd,
                                                   input logic [REG_W-1:0] base);
        return vd - base;
    endfunction

endpackage

// File: rtl/record_mask_decoder.sv
// Turns one committed lane beat (group-relative register, offset, strobe)
// into the set of element-mask bits it completes.
module record_mask_decoder
    import chaining_record_pkg::*;
#(
    parameter int unsigned LANES = 8
) (
    input  logic [REL_W-1:0]    rel,
    input  logic [OFFSET_W-1:0] offset,
    input  logic [LANES-1:0]    strobe,
    output logic [MASK_W-1:0]   set_vec
);

    localparam int unsigned BASE_W = REL_W + OFFSET_W;

    logic [BASE_W-1:0] base;

    // ELEM_PER_REG is 2**OFFSET_W, so rel*ELEM_PER_REG + offset is a plain concatenation.
    always_comb begin
        base    = {rel, offset};
        set_vec = MASK_W'(strobe) << base;
    end

endmodule

// File: rtl/chaining_record_writer.sv
// Producer side of the write-hazard record: allocates on issue, accumulates
// per-element completion as lanes commit, and releases on instruction done.
module chaining_record_writer
    import chaining_record_pkg::*;
#(
    parameter int unsigned LANES = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                alloc_valid,
    output logic                alloc_ready,
    input  logic                alloc_bits_vd_valid,
    input  logic [REG_W-1:0]    alloc_bits_vd_bits,
    input  logic                alloc_bits_vs1_valid,
    input  logic [REG_W-1:0]    alloc_bits_vs1_bits,
    input  logic [REG_W-1:0]    alloc_bits_vs2,
    input  logic [INST_W-1:0]   alloc_bits_instIndex,
    input  logic                alloc_bits_gather,
    input  logic                alloc_bits_gather16,
    input  logic                alloc_bits_onlyRead,
    input  logic                update_valid,
    input  logic [INST_W-1:0]   update_instIndex,
    input  logic [REG_W-1:0]    update_vd,
    input  logic [OFFSET_W-1:0] update_offset,
    input  logic [LANES-1:0]    update_strobe,
    input  logic                done_valid,
    input  logic [INST_W-1:0]   done_instIndex,
    output logic                record_valid,
    output logic                record_bits_vd_valid,
    output logic [REG_W-1:0]    record_bits_vd_bits,
    output logic                record_bits_vs1_valid,
    output logic [REG_W-1:0]    record_bits_vs1_bits,
    output logic [REG_W-1:0]    record_bits_vs2,
    output logic [INST_W-1:0]   record_bits_instIndex,
    output logic                record_bits_gather,
    output logic                record_bits_gather16,
    output logic                record_bits_onlyRead,
    output logic [MASK_W-1:0]   record_bits_elementMask,
    output logic                all_written,
    output logic                update_drop
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t              state;
    record_t             rec;
    record_t             alloc_rec;
    logic [MASK_W-1:0]   mask;
    logic [MASK_W-1:0]   set_vec;
    logic [REG_W-1:0]    rel;
    logic                drop_q;
    logic                done_match;
    logic                alloc_fire;
    logic                update_accept;

    always_comb begin
        done_match    = (state == ACTIVE) && done_valid && (done_instIndex == rec.inst_index);
        alloc_ready   = (state == IDLE) || done_match;
        alloc_fire    = alloc_valid && alloc_ready;
        rel           = rel_group(update_vd, rec.vd_bits);
        update_accept = update_valid && (state == ACTIVE) &&
                        (update_instIndex == rec.inst_index) && rec.vd_valid &&
                        (rel < REG_W'(GROUP_REGS)) && !done_match;

        alloc_rec.vd_valid   = alloc_bits_vd_valid;
        alloc_rec.vd_bits    = alloc_bits_vd_bits;
        alloc_rec.vs1_valid  = alloc_bits_vs1_valid;
        alloc_rec.vs1_bits   = alloc_bits_vs1_bits;
        alloc_rec.vs2        = alloc_bits_vs2;
        alloc_rec.inst_index = alloc_bits_instIndex;
        alloc_rec.gather     = alloc_bits_gather;
        alloc_rec.gather16   = alloc_bits_gather16;
        alloc_rec.only_read  = alloc_bits_onlyRead;
    end

    record_mask_decoder #(.LANES(LANES)) u_decoder (
        .rel     (rel[REL_W-1:0]),
        .offset  (update_offset),
        .strobe  (update_strobe),
        .set_vec (set_vec)
    );

    // A same-cycle done+alloc takes the alloc branch so the new record replaces the old with no gap.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state  <= IDLE;
            rec    <= '0;
            mask   <= '0;
            drop_q <= 1'b0;
        end else begin
            drop_q <= update_valid && !update_accept;
            if (alloc_fire) begin
                state <= ACTIVE;
                rec   <= alloc_rec;
                mask  <= alloc_bits_vd_valid ? '0 : '1;
            end else if (done_match) begin
                state <= IDLE;
                mask  <= '0;
            end else if (update_accept) begin
                mask <= mask | set_vec;
            end
        end
    end

    always_comb begin
        record_valid            = (state == ACTIVE);
        record_bits_vd_valid    = rec.vd_valid;
        record_bits_vd_bits     = rec.vd_bits;
        record_bits_vs1_valid   = rec.vs1_valid;
        record_bits_vs1_bits    = rec.vs1_bits;
        record_bits_vs2         = rec.vs2;
        record_bits_instIndex   = rec.inst_index;
        record_bits_gather      = rec.gather;
        record_bits_gather16    = rec.gather16;
        record_bits_onlyRead    = rec.only_read;
        record_bits_elementMask = mask;
        all_written             = (state == ACTIVE) && (&mask);
        update_drop             = drop_q;
    end

endmodule

// File: doc/chaining_record_writer.md
Name: chaining_record_writer

Overview:
- Producer side of the write-hazard record consumed by the write checker.
- Holds one in-flight instruction record: register groups, instIndex and flag bits, plus a per-element completion mask.
- Allocates the record on instruction issue and sets mask bits as lanes commit element writes.
- Releases the record on instruction completion.
- Mask bit = 1 means that element is already written, so it is no longer a hazard; bit 0 means still pending.

Parameters:
- ELEM_PER_REG, 512, elements per vector register (offset width = log2 = 9).
- GROUP_REGS, 8, registers covered by one record (mask width = ELEM_PER_REG*GROUP_REGS = 4096).
- LANES, 8, elements committed per update beat; must divide ELEM_PER_REG.

Ports:
- clock  in  1  Clock.
- reset  in  1  Synchronous reset, active-low: reset==0 at a clock edge resets all state.
- alloc_valid  in  1  Issue request.
- alloc_ready  out  1  Writer can accept an allocation.
- alloc_bits_vd_valid / vd_bits  in  1/5  Destination group.
- alloc_bits_vs1_valid / vs1_bits  in  1/5  Source 1 group.
- alloc_bits_vs2  in  5  Source 2 group.
- alloc_bits_instIndex  in  3  Instruction tag.
- alloc_bits_gather / gather16 / onlyRead  in  1 each  Flags, stored verbatim.
- update_valid  in  1  Lane write commit.
- update_instIndex  in  3  Tag of the committing instruction.
- update_vd  in  5  Absolute register written.
- update_offset  in  9  First element of the beat; LANES-aligned.
- update_strobe  in  LANES  Per-element commit bits.
- done_valid / done_instIndex  in  1/3  Instruction completion.
- record_valid  out  1  Record live.
- record_bits_*  out  as alloc  Stored fields, same names as the checker inputs.
- record_bits_elementMask  out  4096  Completion mask.
- all_written  out  1  Record live and mask all ones.
- update_drop  out  1  Pulse: a valid update was ignored.

Behaviour:
- Reset values:
  - FSM IDLE.
  - record_valid=0; all record_bits_* and the mask = 0.
  - alloc_ready=1, all_written=0, update_drop=0.
- FSM has two states: IDLE and ACTIVE.
- IDLE -> ACTIVE on alloc fire (alloc_valid & alloc_ready). On the following cycle:
  - record_valid=1 and all fields are registered.
  - Mask = all zeros if vd_valid=1, else all ones (a read-only record never blocks writes through vd).
- ACTIVE -> IDLE when done_valid & done_instIndex==record instIndex. record_valid=0 on the next cycle and the mask is cleared. A done with a mismatched tag, or a done while IDLE, is ignored.
- alloc_ready = IDLE | (ACTIVE & matching done this cycle). Back-to-back: done and alloc in the same cycle give a new live record at t+1 with no gap; the alloc wins the register write.
- Update is accepted only when all of these hold:
  - ACTIVE and update_instIndex==record instIndex;
  - record vd_valid=1;
  - rel = (update_vd - record vd_bits) mod 32 < GROUP_REGS;
  - no matching done in the same cycle.
- For an accepted update, for each i with strobe[i]=1, mask bit (rel[2:0]*ELEM_PER_REG + update_offset + i) is set. Bits are only ever set, never cleared, while ACTIVE. The update is visible on the output 1 cycle later.
- Wrap: record vd=30 with update_vd=1 gives rel=3, which is accepted (modulo-32 arithmetic).
- A valid update that fails acceptance pulses update_drop for 1 cycle; the mask is unchanged. An all-zero strobe is accepted, is a no-op, and is not a drop.
- all_written is combinational from registered state; it does not trigger release.
- Reset asserted mid-operation: the next cycle returns to reset values regardless of other inputs.

Decomposition:
- Package chaining_record_pkg holds:
  - constants ELEM_PER_REG, GROUP_REGS, OFFSET_W=9, INST_W=3, REG_W=5, MASK_W;
  - packed struct record_t (all record_bits_* fields except the mask);
  - function rel_group(vd, base).
- One sub-module, record_mask_decoder (combinational): takes rel, offset and strobe, and returns a MASK_W set-vector. The top ORs this into the mask register.

Test Plan:
- Alloc vd=8, vd_valid=1, instIndex=2. Then, with record ACTIVE:
  - update vd=9, offset=16, strobe=0x0F -> mask bits 528..531 =1 one cycle later, all other bits 0;
  - update_instIndex=3 -> update_drop pulse, mask unchanged.
- Alloc vd=30, then update vd=1 offset=0 strobe=0x01 -> bit 1536 set; update vd=6 (rel=8) -> update_drop=1.
- Alloc vd_valid=0 onlyRead=1 -> next cycle mask all ones, all_written=1.
- ACTIVE with instIndex=5; same cycle drive done(5) + alloc(instIndex=6, vd=16) -> next cycle record_valid=1, instIndex=6, mask zero; alloc_ready was 1 in that cycle.
- Same cycle: update + matching done -> record released, update_drop=1. Separately, fill all 512 beats -> all_written=1 and record stays valid until done.
- reset=0 while ACTIVE with a partially set mask -> next cycle record_valid=0, mask 0, alloc_ready=1.
